// File: rtl/xga_pkg.sv
// Shared constants for the video compositor: config register map and the
// default pixel type derived from the default colour depth.
package xga_pkg;

  localparam int XGA_COLOR_W = 4;
  localparam int XGA_PIX_W   = 3 * XGA_COLOR_W;

  typedef logic [XGA_PIX_W-1:0] pix_t;

  localparam logic [3:0] CFG_ENABLE = 4'd0;
  localparam logic [3:0] CFG_BG     = 4'd1;
  localparam logic [3:0] CFG_KEY0   = 4'd2;
  localparam logic [3:0] CFG_CTRL   = 4'd15;

endpackage

// File: rtl/compositor_cfg.sv
// Shadow/active configuration registers for the compositor; shadow values are
// promoted to active on the vsync falling edge when a write is pending.
module compositor_cfg
  import xga_pkg::*;
#(
  parameter int  N_LAYERS = 2,
  parameter int  COLOR_W  = XGA_COLOR_W,
  localparam int PIX_W    = 3 * COLOR_W
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic                      cfg_wr_i,
  input  logic [3:0]                cfg_addr_i,
  input  logic [31:0]               cfg_data_i,
  input  logic                      vsync_i,
  output logic [N_LAYERS-1:0]       en_o,
  output logic [PIX_W-1:0]          bg_o,
  output logic [N_LAYERS*PIX_W-1:0] key_o,
  output logic [N_LAYERS-1:0]       key_en_o,
  output logic                      pending_o
);

  localparam logic [N_LAYERS-1:0] KEN_RST = {1'b0, {(N_LAYERS-1){1'b1}}};

  logic [N_LAYERS-1:0]       sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [PIX_W-1:0]          sh_bg_q, sh_bg_d, act_bg_q, act_bg_d;
  logic [N_LAYERS*PIX_W-1:0] sh_key_q, sh_key_d, act_key_q, act_key_d;
  logic [N_LAYERS-1:0]       sh_ken_q, sh_ken_d, act_ken_q, act_ken_d;
  logic                      pending_q, pending_d;
  logic                      vs_prev_q;
  logic                      frame_start_s;
  logic                      shadow_wr_s;
  logic                      unused_data_s;

  assign frame_start_s = vs_prev_q & ~vsync_i;
  assign unused_data_s = ^cfg_data_i[30:PIX_W];

  // Promotion reads the pre-write shadow, so a coincident write stays pending.
  always_comb begin
    sh_en_d     = sh_en_q;
    sh_bg_d     = sh_bg_q;
    sh_key_d    = sh_key_q;
    sh_ken_d    = sh_ken_q;
    shadow_wr_s = 1'b0;
    if (frame_start_s && pending_q) begin
      act_en_d  = sh_en_q;
      act_bg_d  = sh_bg_q;
      act_key_d = sh_key_q;
      act_ken_d = sh_ken_q;
    end else begin
      act_en_d  = act_en_q;
      act_bg_d  = act_bg_q;
      act_key_d = act_key_q;
      act_ken_d = act_ken_q;
    end
    if (cfg_wr_i) begin
      if (cfg_addr_i == CFG_ENABLE) begin
        sh_en_d     = cfg_data_i[N_LAYERS-1:0];
        shadow_wr_s = 1'b1;
      end else if (cfg_addr_i == CFG_BG) begin
        sh_bg_d     = cfg_data_i[PIX_W-1:0];
        shadow_wr_s = 1'b1;
      end else begin
        for (int k = 0; k < N_LAYERS; k++) begin
          if (cfg_addr_i == CFG_KEY0 + 4'(k)) begin
            sh_key_d[k*PIX_W +: PIX_W] = cfg_data_i[PIX_W-1:0];
            sh_ken_d[k]                = cfg_data_i[31];
            shadow_wr_s                = 1'b1;
          end else begin
            sh_ken_d[k] = sh_ken_d[k];
          end
        end
      end
    end else begin
      shadow_wr_s = 1'b0;
    end
    if (shadow_wr_s) begin
      pending_d = 1'b1;
    end else if (frame_start_s && pending_q) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sh_en_q   <= {N_LAYERS{1'b1}};
      act_en_q  <= {N_LAYERS{1'b1}};
      sh_bg_q   <= {PIX_W{1'b0}};
      act_bg_q  <= {PIX_W{1'b0}};
      sh_key_q  <= {(N_LAYERS*PIX_W){1'b0}};
      act_key_q <= {(N_LAYERS*PIX_W){1'b0}};
      sh_ken_q  <= KEN_RST;
      act_ken_q <= KEN_RST;
      pending_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      sh_en_q   <= sh_en_d;
      act_en_q  <= act_en_d;
      sh_bg_q   <= sh_bg_d;
      act_bg_q  <= act_bg_d;
      sh_key_q  <= sh_key_d;
      act_key_q <= act_key_d;
      sh_ken_q  <= sh_ken_d;
      act_ken_q <= act_ken_d;
      pending_q <= pending_d;
      vs_prev_q <= vsync_i;
    end
  end

  assign en_o      = act_en_q;
  assign bg_o      = act_bg_q;
  assign key_o     = act_key_q;
  assign key_en_o  = act_ken_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/video_compositor.sv
// Two-stage priority layer compositor with colour keying, background fill and
// sticky per-layer underflow flags.
module video_compositor
  import xga_pkg::*;
#(
  parameter int  N_LAYERS = 2,
  parameter int  COLOR_W  = XGA_COLOR_W,
  localparam int PIX_W    = 3 * COLOR_W
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic [N_LAYERS*PIX_W-1:0] layer_pix_i,
  input  logic [N_LAYERS-1:0]       layer_valid_i,
  input  logic                      de_i,
  input  logic                      hsync_i,
  input  logic                      vsync_i,
  input  logic                      cfg_wr_i,
  input  logic [3:0]                cfg_addr_i,
  input  logic [31:0]               cfg_data_i,
  output logic [PIX_W-1:0]          pix_o,
  output logic                      de_o,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      cfg_pending_o,
  output logic [N_LAYERS-1:0]       underflow_o
);

  logic [N_LAYERS-1:0]       en_s, key_en_s, opaque_s;
  logic [PIX_W-1:0]          bg_s, sel_s, pix_d;
  logic [N_LAYERS*PIX_W-1:0] key_s;
  logic [N_LAYERS*PIX_W-1:0] lpix_q;
  logic [N_LAYERS-1:0]       lvalid_q;
  logic                      de1_q, hs1_q, vs1_q;
  logic [PIX_W-1:0]          pix_q;
  logic                      de_q, hs_q, vs_q;
  logic [N_LAYERS-1:0]       uf_q, uf_d;
  logic                      uf_clr_s;

  compositor_cfg #(
    .N_LAYERS (N_LAYERS),
    .COLOR_W  (COLOR_W)
  ) u_cfg (
    .clk        (clk),
    .reset_i    (reset_i),
    .cfg_wr_i   (cfg_wr_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_data_i (cfg_data_i),
    .vsync_i    (vsync_i),
    .en_o       (en_s),
    .bg_o       (bg_s),
    .key_o      (key_s),
    .key_en_o   (key_en_s),
    .pending_o  (cfg_pending_o)
  );

  // Walk from lowest priority upward so the lowest opaque index wins.
  always_comb begin
    sel_s = bg_s;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      opaque_s[k] = en_s[k] & lvalid_q[k] &
                    ~(key_en_s[k] & (lpix_q[k*PIX_W +: PIX_W] == key_s[k*PIX_W +: PIX_W]));
      sel_s = opaque_s[k] ? lpix_q[k*PIX_W +: PIX_W] : sel_s;
    end
    pix_d = de1_q ? sel_s : {PIX_W{1'b0}};
  end

  // Set beats clear when both hit the same flag.
  assign uf_clr_s = cfg_wr_i & (cfg_addr_i == CFG_CTRL) & cfg_data_i[0];
  assign uf_d     = (uf_q & ~{N_LAYERS{uf_clr_s}}) | ({N_LAYERS{de_i}} & en_s & ~layer_valid_i);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      lpix_q   <= {(N_LAYERS*PIX_W){1'b0}};
      lvalid_q <= {N_LAYERS{1'b0}};
      de1_q    <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      pix_q    <= {PIX_W{1'b0}};
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      uf_q     <= {N_LAYERS{1'b0}};
    end else begin
      lpix_q   <= layer_pix_i;
      lvalid_q <= layer_valid_i;
      de1_q    <= de_i;
      hs1_q    <= hsync_i;
      vs1_q    <= vsync_i;
      pix_q    <= pix_d;
      de_q     <= de1_q;
      hs_q     <= hs1_q;
      vs_q     <= vs1_q;
      uf_q     <= uf_d;
    end
  end

  assign pix_o       = pix_q;
  assign de_o        = de_q;
  assign hsync_o     = hs_q;
  assign vsync_o     = vs_q;
  assign underflow_o = uf_q;

endmodule

// File: tb/tb_video_compositor.sv
// Directed bench for video_compositor: a frame-level reference model checked
// every cycle, plus hand-computed spot values.
module tb_video_compositor;
  import xga_pkg::*;

  localparam int N  = 2;
  localparam int CW = 4;
  localparam int PW = 3 * CW;

  logic          clk;
  logic          reset_i;
  logic [N*PW-1:0] layer_pix_i;
  logic [N-1:0]  layer_valid_i;
  logic          de_i, hsync_i, vsync_i;
  logic          cfg_wr_i;
  logic [3:0]    cfg_addr_i;
  logic [31:0]   cfg_data_i;
  pix_t          pix_o;
  logic          de_o, hsync_o, vsync_o;
  logic          cfg_pending_o;
  logic [N-1:0]  underflow_o;

  int n_cmp  = 0;
  int n_fail = 0;

  video_compositor #(.N_LAYERS(N), .COLOR_W(CW)) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .layer_pix_i   (layer_pix_i),
    .layer_valid_i (layer_valid_i),
    .de_i          (de_i),
    .hsync_i       (hsync_i),
    .vsync_i       (vsync_i),
    .cfg_wr_i      (cfg_wr_i),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_data_i    (cfg_data_i),
    .pix_o         (pix_o),
    .de_o          (de_o),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o),
    .cfg_pending_o (cfg_pending_o),
    .underflow_o   (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0]  m_sh_en, m_en;
  logic [PW-1:0] m_sh_bg, m_bg;
  logic [PW-1:0] m_sh_key [N];
  logic [PW-1:0] m_key    [N];
  logic          m_sh_ken [N];
  logic          m_ken    [N];
  logic          m_pend;
  logic [N-1:0]  m_uf;
  logic          m_vs_prev;
  logic [PW+2:0] m_s1, m_s2;   // {pix, de, hs, vs}

  initial begin : model
    logic          fs;
    logic          found;
    logic [PW-1:0] p, outp;
    forever begin
      @(posedge clk);
      if (reset_i) begin
        m_sh_en = '1; m_en = '1; m_sh_bg = '0; m_bg = '0;
        for (int k = 0; k < N; k++) begin
          m_sh_key[k] = '0; m_key[k] = '0;
          m_sh_ken[k] = (k != N - 1); m_ken[k] = (k != N - 1);
        end
        m_pend = 1'b0; m_uf = '0; m_vs_prev = 1'b0; m_s1 = '0; m_s2 = '0;
      end else begin
        fs = m_vs_prev && !vsync_i;
        for (int k = 0; k < N; k++)
          if (de_i && m_en[k] && !layer_valid_i[k]) m_uf[k] = 1'b1;
          else if (cfg_wr_i && cfg_addr_i == 4'd15 && cfg_data_i[0]) m_uf[k] = 1'b0;
        if (fs && m_pend) begin
          m_en = m_sh_en; m_bg = m_sh_bg;
          for (int k = 0; k < N; k++) begin m_key[k] = m_sh_key[k]; m_ken[k] = m_sh_ken[k]; end
          m_pend = 1'b0;
        end
        if (cfg_wr_i) begin
          if (cfg_addr_i == 4'd0) begin m_sh_en = cfg_data_i[N-1:0]; m_pend = 1'b1; end
          else if (cfg_addr_i == 4'd1) begin m_sh_bg = cfg_data_i[PW-1:0]; m_pend = 1'b1; end
          else if (int'(cfg_addr_i) >= 2 && int'(cfg_addr_i) < 2 + N) begin
            m_sh_key[int'(cfg_addr_i) - 2] = cfg_data_i[PW-1:0];
            m_sh_ken[int'(cfg_addr_i) - 2] = cfg_data_i[31];
            m_pend = 1'b1;
          end
        end
        outp = m_bg; found = 1'b0;
        for (int k = 0; k < N; k++) begin
          p = layer_pix_i[k*PW +: PW];
          if (!found && m_en[k] && layer_valid_i[k] && !(m_ken[k] && p == m_key[k])) begin
            outp = p; found = 1'b1;
          end
        end
        if (!de_i) outp = '0;
        m_s2 = m_s1;
        m_s1 = {outp, de_i, hsync_i, vsync_i};
        m_vs_prev = vsync_i;
      end
    end
  end

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("pix_o", 32'(pix_o), 32'(m_s2[PW+2:3]));
      chk("de_o", 32'(de_o), 32'(m_s2[2]));
      chk("hsync_o", 32'(hsync_o), 32'(m_s2[1]));
      chk("vsync_o", 32'(vsync_o), 32'(m_s2[0]));
      chk("cfg_pending_o", 32'(cfg_pending_o), 32'(m_pend));
      chk("underflow_o", 32'(underflow_o), 32'(m_uf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                       input logic [N-1:0] v, input logic de);
    layer_pix_i   = {p1, p0};
    layer_valid_i = v;
    de_i          = de;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_wr_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    tick(1);
    cfg_wr_i = 1'b0; cfg_addr_i = 4'd0; cfg_data_i = 32'd0;
  endtask

  task automatic frame_start();
    vsync_i = 1'b1;
    tick(1);
    vsync_i = 1'b0;
    tick(1);
  endtask

  typedef struct { logic [PW-1:0] p0; logic [PW-1:0] p1; logic [N-1:0] v; logic de; logic hs; } vec_t;
  vec_t vecs [6];

  initial begin : main
    reset_i = 1'b1; layer_pix_i = '0; layer_valid_i = '0;
    de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    cfg_wr_i = 1'b0; cfg_addr_i = 4'd0; cfg_data_i = 32'd0;
    tick(3);
    chk("reset pix_o", 32'(pix_o), 32'h0);
    chk("reset de_o", 32'(de_o), 32'h0);
    chk("reset pending", 32'(cfg_pending_o), 32'h0);
    chk("reset underflow", 32'(underflow_o), 32'h0);

    // Defaults: layer0 black is keyed out, layer1 shows, latency exactly 2.
    reset_i = 1'b0;
    drive(12'h000, 12'h5A3, 2'b11, 1'b1);
    tick(1);
    chk("latency not 1", 32'(pix_o), 32'h0);
    tick(1);
    chk("default key pix", 32'(pix_o), 32'h5A3);
    chk("default de_o", 32'(de_o), 32'h1);

    // Priority, then mask change applied at frame start.
    drive(12'h0F0, 12'h5A3, 2'b11, 1'b1);
    tick(2);
    chk("priority pix", 32'(pix_o), 32'h0F0);
    cfg_write(4'd0, 32'h2);
    chk("pending after write", 32'(cfg_pending_o), 32'h1);
    chk("shadow not active", 32'(pix_o), 32'h0F0);
    frame_start();
    chk("pending cleared", 32'(cfg_pending_o), 32'h0);
    tick(1);
    chk("mask applied pix", 32'(pix_o), 32'h5A3);

    // Background with every layer disabled.
    cfg_write(4'd1, 32'h123);
    cfg_write(4'd0, 32'h0);
    frame_start();
    tick(1);
    chk("background pix", 32'(pix_o), 32'h123);
    drive(12'h0F0, 12'h5A3, 2'b11, 1'b0);
    tick(2);
    chk("blank pix", 32'(pix_o), 32'h0);
    chk("blank de_o", 32'(de_o), 32'h0);

    // Underflow flags: set, clear, set-wins-over-clear.
    cfg_write(4'd0, 32'h3);
    frame_start();
    drive(12'h0F0, 12'h5A3, 2'b01, 1'b1);
    tick(1);
    chk("underflow set", 32'(underflow_o), 32'h2);
    tick(1);
    chk("underflow pix", 32'(pix_o), 32'h0F0);
    drive(12'h0F0, 12'h5A3, 2'b11, 1'b1);
    cfg_write(4'd15, 32'h1);
    chk("underflow cleared", 32'(underflow_o), 32'h0);
    drive(12'h0F0, 12'h5A3, 2'b01, 1'b1);
    cfg_write(4'd15, 32'h1);
    chk("set beats clear", 32'(underflow_o), 32'h2);
    drive(12'h000, 12'h5A3, 2'b01, 1'b1);
    tick(2);
    chk("all transparent bg", 32'(pix_o), 32'h123);
    drive(12'h0F0, 12'h5A3, 2'b11, 1'b1);
    cfg_write(4'd15, 32'h1);

    // Key write landing on the frame-start cycle.
    cfg_write(4'd1, 32'h456);
    drive(12'hABC, 12'h5A3, 2'b11, 1'b1);
    vsync_i = 1'b1;
    tick(1);
    vsync_i = 1'b0;
    cfg_write(4'd2, 32'h8000_0ABC);
    chk("pending kept", 32'(cfg_pending_o), 32'h1);
    tick(1);
    chk("old key active", 32'(pix_o), 32'hABC);
    frame_start();
    chk("pending after 2nd fs", 32'(cfg_pending_o), 32'h0);
    tick(1);
    chk("new key active", 32'(pix_o), 32'h5A3);

    // Mixed vectors checked by the model only.
    vecs[0] = '{12'h111, 12'h222, 2'b11, 1'b1, 1'b0};
    vecs[1] = '{12'hABC, 12'h222, 2'b10, 1'b1, 1'b1};
    vecs[2] = '{12'h333, 12'h444, 2'b00, 1'b1, 1'b1};
    vecs[3] = '{12'h555, 12'h666, 2'b01, 1'b0, 1'b0};
    vecs[4] = '{12'hFFF, 12'hABC, 2'b11, 1'b1, 1'b0};
    vecs[5] = '{12'hABC, 12'hABC, 2'b11, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].p0, vecs[i].p1, vecs[i].v, vecs[i].de);
      hsync_i = vecs[i].hs;
      tick(1);
    end
    hsync_i = 1'b0;

    // Mid-frame reset discards in-flight pixels and restores defaults.
    drive(12'h777, 12'h888, 2'b11, 1'b1);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    drive(12'h000, 12'h5A3, 2'b11, 1'b1);
    tick(1);
    chk("flushed pix", 32'(pix_o), 32'h0);
    chk("flushed underflow", 32'(underflow_o), 32'h0);
    tick(1);
    chk("post-reset pix", 32'(pix_o), 32'h5A3);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/video_compositor.md
VIDEO_COMPOSITOR -- requirements
Module: video_compositor

Interface
REQ-001 SHALL have parameter N_LAYERS, default 2: number of input layers, 2..8; layer 0 is highest priority.
REQ-002 SHALL have parameter COLOR_W, default 4: bits per colour channel, 4..8; pixel width PIX_W = 3*COLOR_W, packed R,G,B from MSB.
REQ-003 SHALL have ports:
- clk  in  1: single clock; one clock, all logic on rising edge
- reset_i  in  1: synchronous, active-high reset
- layer_pix_i  in  N_LAYERS*PIX_W: layer k occupies bits [k*PIX_W +: PIX_W]
- layer_valid_i  in  N_LAYERS: layer k pixel valid this cycle
- de_i, hsync_i, vsync_i  in  1 each: input timing
- cfg_wr_i  in  1: config write strobe
- cfg_addr_i  in  4: register index
- cfg_data_i  in  32: write data
- pix_o  out  PIX_W: composited pixel
- de_o, hsync_o, vsync_o  out  1 each: delayed timing
- cfg_pending_o  out  1: shadow config not yet applied
- underflow_o  out  N_LAYERS: sticky per-layer underflow flags

Function
REQ-004 SHALL provide config registers:
- addr 0: layer enable mask [N_LAYERS-1:0]
- addr 1: background colour [PIX_W-1:0]
- addr 2+k, k<N_LAYERS: key colour [PIX_W-1:0], key enable bit 31
- addr 15: bit0 = 1 clears underflow_o
- all other addresses ignored
REQ-005 SHALL write addr 0..2+N_LAYERS-1 into shadow registers only, and set cfg_pending_o on the following cycle.
REQ-006 SHALL detect frame start as a falling edge of vsync_i (registered previous value 1, current 0).
REQ-007 SHALL, on frame start with cfg_pending_o=1, copy all shadow registers to active registers in one cycle and clear cfg_pending_o.
REQ-008 SHALL, when a cfg write coincides with the frame start, apply the pre-write shadow values, keep the new value in shadow, and leave cfg_pending_o=1.
REQ-009 SHALL treat layer k as transparent for a pixel when any of these holds: its enable bit is 0; layer_valid_i[k]=0; or its key enable is 1 and its pixel equals its key colour.
REQ-010 SHALL output the lowest-index non-transparent layer pixel; if all layers are transparent, SHALL output the active background colour.
REQ-011 SHALL force pix_o to 0 whenever de_o=0.
REQ-012 SHALL have a fixed latency of exactly 2 cycles from inputs to pix_o, de_o, hsync_o and vsync_o: stage 1 registers the inputs, stage 2 registers the select result; timing outputs are aligned to pix_o.
REQ-013 SHALL use, for compositing, the active config sampled in the same cycle the pixel is in stage 1.
REQ-014 SHALL set underflow_o[k] when de_i=1, enable[k]=1 and layer_valid_i[k]=0; the flag holds until cleared by addr 15 or reset.
REQ-015 SHALL, when set and clear coincide on the same flag, give set priority.
REQ-016 SHALL perform no arithmetic beyond equality compares; the priority select SHALL be a combinational loop over N_LAYERS between stages.

Reset
REQ-017 SHALL, on reset_i, set pix_o=0, de_o=0, hsync_o=0, vsync_o=0, cfg_pending_o=0, underflow_o=0, and clear all pipeline registers.
REQ-018 SHALL reset active and shadow config to:
- enable mask all ones
- background 0
- key enable 1 with key 0 for layers 0..N_LAYERS-2
- key enable 0 for layer N_LAYERS-1
REQ-019 SHALL, on reset asserted mid-frame, discard in-flight pixels; the first valid output appears 2 cycles after the first input following reset release.

Structure
REQ-020 SHALL place the config address constants (CFG_ENABLE=0, CFG_BG=1, CFG_KEY0=2, CFG_CTRL=15) and the COLOR_W-derived pixel typedef in a shared package, xga_pkg.
REQ-021 SHALL use one sub-module, compositor_cfg, holding the shadow/active registers, the pending flag and the frame-start edge detect; the pipeline SHALL live in the top module.

Verification
REQ-022 Reset defaults, N_LAYERS=2, COLOR_W=4: layer0=0x000, layer1=0x5A3, both valid, de=1 -> pix_o=0x5A3 exactly 2 cycles later.
REQ-023 Priority: layer0=0x0F0, layer1=0x5A3 -> pix_o=0x0F0; write addr 0 = 0b10, then vsync_i falling edge -> pix_o=0x5A3 from the next pixel, cfg_pending_o 1 then 0.
REQ-024 Background: write addr 1 = 0x123, mask = 0, then frame start -> pix_o=0x123 while de=1, and 0 while de=0.
REQ-025 Simultaneous write at frame start: write key2 = 0x80000ABC in the frame-start cycle -> old key active, cfg_pending_o stays 1, new key active after the next frame start.
REQ-026 Underflow: layer_valid_i=0b01 during de with layer1 enabled -> underflow_o=0b10 and layer0 pixel or background shown; addr 15 write of 1 -> underflow_o=0 next cycle unless set again in the same cycle.
